// File: rtl/clk_period_meter_if.sv
// Measurement result bus of clk_period_meter: the meter drives results, the consumer drives meas_ack.
interface clk_period_meter_if #(
  parameter int unsigned CNT_W = 26
);
  logic             meas_ack;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_valid;
  logic             overrun;
  logic             stalled;

  modport master (
    input  meas_ack,
    output meas_period, meas_high, meas_valid, overrun, stalled
  );

  modport slave (
    output meas_ack,
    input  meas_period, meas_high, meas_valid, overrun, stalled
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous input in clk_50mhz cycles.
// Define METER_DUTY_EN to build the high-time counter; otherwise meas_high is tied to 0.
module clk_period_meter #(
  parameter int unsigned CNT_W = 26
) (
  input  logic                clk_50mhz,
  input  logic                rst,
  input  logic                clk_in,
  clk_period_meter_if.master  meas
);

  localparam logic [0:0] ARM = 1'b0;
  localparam logic [0:0] RUN = 1'b1;

  logic             s1, s2, s3;
  logic [0:0]       state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] meas_period_q;
  logic             valid_q;
  logic             overrun_q;
  logic             stalled_q;
  logic             rise;
  logic             load;
  logic             sat;

  assign rise = s2 & ~s3;
  assign load = (state == RUN) && rise;
  // Saturation freezes everything, including a pending ack, until the next arm.
  assign sat  = (state == RUN) && !rise && (per_cnt == '1);

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      state         <= ARM;
      per_cnt       <= '0;
      meas_period_q <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      stalled_q     <= 1'b0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;

      case (state)
        ARM: begin
          if (rise) begin
            per_cnt <= CNT_W'(1);
            state   <= RUN;
          end
        end
        default: begin
          if (rise) begin
            meas_period_q <= per_cnt;
            per_cnt       <= CNT_W'(1);
            stalled_q     <= 1'b0;
            if (valid_q && !meas.meas_ack)
              overrun_q <= 1'b1;
          end else if (sat) begin
            state     <= ARM;
            stalled_q <= 1'b1;
          end else begin
            per_cnt <= per_cnt + CNT_W'(1);
          end
        end
      endcase

      if (load)
        valid_q <= 1'b1;
      else if (valid_q && meas.meas_ack && !sat)
        valid_q <= 1'b0;
    end
  end

`ifdef METER_DUTY_EN
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] meas_high_q;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      hi_cnt      <= '0;
      meas_high_q <= '0;
    end else if (state == ARM) begin
      if (rise)
        hi_cnt <= CNT_W'(1);
    end else if (rise) begin
      meas_high_q <= hi_cnt;
      hi_cnt      <= CNT_W'(1);
    end else if (!sat) begin
      hi_cnt <= hi_cnt + CNT_W'(s2);
    end
  end

  assign meas.meas_high = meas_high_q;
`else
  assign meas.meas_high = '0;
`endif

  assign meas.meas_period = meas_period_q;
  assign meas.meas_valid  = valid_q;
  assign meas.overrun     = overrun_q;
  assign meas.stalled     = stalled_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a default-width meter and a CNT_W=6 meter for the stall case.
// Expected high times follow METER_DUTY_EN (measured count when defined, 0 otherwise).
module tb_clk_period_meter;

`ifdef METER_DUTY_EN
  localparam int unsigned HI11 = 11;
  localparam int unsigned HI10 = 10;
`else
  localparam int unsigned HI11 = 0;
  localparam int unsigned HI10 = 0;
`endif

  logic clk_50mhz;
  logic rst_a, rst_b;
  logic clk_in;

  int unsigned errors = 0;
  int unsigned checks = 0;

  bit          wave_on  = 1'b0;
  int unsigned wave_per = 22;
  int unsigned wave_hi  = 11;
  int unsigned phase    = 0;

  clk_period_meter_if #(.CNT_W(26)) ma ();
  clk_period_meter_if #(.CNT_W(6))  mb ();

  clk_period_meter #(.CNT_W(26)) dut_a (
    .clk_50mhz (clk_50mhz),
    .rst       (rst_a),
    .clk_in    (clk_in),
    .meas      (ma.master)
  );

  clk_period_meter #(.CNT_W(6)) dut_b (
    .clk_50mhz (clk_50mhz),
    .rst       (rst_b),
    .clk_in    (clk_in),
    .meas      (mb.master)
  );

  initial begin
    clk_50mhz = 1'b0;
    forever #10 clk_50mhz = ~clk_50mhz;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_50mhz);
    #1;
    if (wave_on) begin
      phase  = (phase + 1) % wave_per;
      clk_in = (phase < wave_hi);
    end
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic start_wave(input int unsigned per, input int unsigned hi);
    wave_per = per;
    wave_hi  = hi;
    phase    = 0;
    clk_in   = 1'b1;
    wave_on  = 1'b1;
  endtask

  task automatic wait_valid(input bit on_b, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (((on_b ? mb.meas_valid : ma.meas_valid) !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(on_b ? mb.meas_valid : ma.meas_valid), 32'd1);
  endtask

  task automatic ack_a();
    ma.meas_ack = 1'b1;
    step();
    ma.meas_ack = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    clk_in = 1'b0;
    ma.meas_ack = 1'b0;
    mb.meas_ack = 1'b0;
    steps(2);

    chk("rst_period", ma.meas_period, 0);
    chk("rst_high",   ma.meas_high,   0);
    chk("rst_valid",  32'(ma.meas_valid), 0);
    chk("rst_overrun", 32'(ma.overrun), 0);
    chk("rst_stalled", 32'(ma.stalled), 0);

    // Basic measurement: 22-cycle square wave, first rise only arms
    rst_a = 1'b0;
    start_wave(22, 11);
    steps(15);
    chk("first_rise_no_valid", 32'(ma.meas_valid), 0);
    wait_valid(1'b0, 40, "basic_valid");
    chk("basic_period", ma.meas_period, 22);
    chk("basic_high",   ma.meas_high,   HI11);
    steps(5);
    chk("valid_held", 32'(ma.meas_valid), 1);
    ack_a();
    chk("ack_clears", 32'(ma.meas_valid), 0);
    chk("no_overrun", 32'(ma.overrun), 0);
    ack_a();
    chk("ack_ignored_low", 32'(ma.meas_valid), 0);

    // Overrun: two measurements without ack
    wait_valid(1'b0, 40, "ovr_first_valid");
    steps(21);
    chk("ovr_not_yet", 32'(ma.overrun), 0);
    step();
    chk("ovr_set",    32'(ma.overrun), 1);
    chk("ovr_valid",  32'(ma.meas_valid), 1);
    chk("ovr_period", ma.meas_period, 22);
    ack_a();
    chk("ovr_ack_valid",  32'(ma.meas_valid), 0);
    chk("ovr_sticky",     32'(ma.overrun), 1);

    // Reset mid-measurement with clk_in high
    for (int unsigned i = 0; i < 30 && clk_in !== 1'b1; i++) step();
    steps(3);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("mrst_period",  ma.meas_period, 0);
    chk("mrst_high",    ma.meas_high,   0);
    chk("mrst_valid",   32'(ma.meas_valid), 0);
    chk("mrst_overrun", 32'(ma.overrun), 0);
    chk("mrst_stalled", 32'(ma.stalled), 0);
    steps(10);
    chk("mrst_arm_only", 32'(ma.meas_valid), 0);
    wait_valid(1'b0, 40, "mrst_partial_valid");
    ack_a();
    wait_valid(1'b0, 40, "mrst_valid");
    chk("mrst_full_period", ma.meas_period, 22);
    chk("mrst_full_high",   ma.meas_high,   HI11);

    // Ack in exactly the rise cycle while valid is high
    steps(21);
    ma.meas_ack = 1'b1;
    step();
    ma.meas_ack = 1'b0;
    chk("sim_valid",   32'(ma.meas_valid), 1);
    chk("sim_overrun", 32'(ma.overrun), 0);
    chk("sim_period",  ma.meas_period, 22);
    step();
    chk("sim_valid_kept", 32'(ma.meas_valid), 1);
    ack_a();

    // 30-cycle period, 10 cycles high
    start_wave(30, 10);
    wait_valid(1'b0, 60, "p30_transition_valid");
    ack_a();
    wait_valid(1'b0, 60, "p30_valid");
    chk("p30_period", ma.meas_period, 30);
    chk("p30_high",   ma.meas_high,   HI10);
    ack_a();

    // Stall and recovery on the 6-bit meter
    rst_b = 1'b0;
    start_wave(22, 11);
    wait_valid(1'b1, 60, "b_valid");
    chk("b_period", mb.meas_period, 22);
    mb.meas_ack = 1'b1;
    wave_on = 1'b0;
    clk_in = 1'b0;
    step();
    mb.meas_ack = 1'b0;
    chk("b_ack_clears", 32'(mb.meas_valid), 0);
    steps(54);
    chk("b_not_stalled_yet", 32'(mb.stalled), 0);
    for (int unsigned i = 0; i < 20 && mb.stalled !== 1'b1; i++) step();
    chk("b_stalled", 32'(mb.stalled), 1);
    chk("b_stall_valid", 32'(mb.meas_valid), 0);
    chk("b_stall_period_kept", mb.meas_period, 22);
    start_wave(22, 11);
    steps(15);
    chk("b_rearm_no_valid", 32'(mb.meas_valid), 0);
    chk("b_rearm_stalled",  32'(mb.stalled), 1);
    wait_valid(1'b1, 40, "b_recover_valid");
    chk("b_recover_period",  mb.meas_period, 22);
    chk("b_recover_high",    mb.meas_high,   HI11);
    chk("b_recover_stalled", 32'(mb.stalled), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
